// File: rtl/trace_tpiu_tx.sv
// TPIU trace port transmitter: serialises halfwords, pads and full syncs onto a
// 1/2/4-bit DDR TRACEDATA pair, LSB first, with the older bits on the rising half.
module trace_tpiu_tx #(
    parameter int unsigned BUSWIDTH    = 4,
    parameter int unsigned SYNC_FRAMES = 16,
    parameter int unsigned SYNC_IDLE   = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [2:0]          width,
    input  logic                forceSync,
    input  logic                WdValid,
    input  logic [15:0]         PacketWd,
    output logic                WdReady,
    output logic [BUSWIDTH-1:0] traceDouta,
    output logic [BUSWIDTH-1:0] traceDoutb,
    output logic                syncActive,
    output logic                frameDone
);

    localparam logic [1:0] StReset = 2'd0;
    localparam logic [1:0] StSync  = 2'd1;
    localparam logic [1:0] StData  = 2'd2;
    localparam logic [1:0] StBad   = 2'd3;

    localparam logic [31:0] SyncWord = 32'h7fff_ffff;
    localparam logic [15:0] PadWord  = 16'h7fff;

    logic [1:0]  state_q, state_d;
    logic [31:0] sh_q, sh_d;
    logic [2:0]  lw_q, lw_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [2:0]  word_cnt_q, word_cnt_d;
    logic [7:0]  frame_cnt_q, frame_cnt_d;
    logic [7:0]  pad_cnt_q, pad_cnt_d;
    logic        frame_done_q, frame_done_d;

    logic width_ok;
    logic out_en;
    logic slot_end;
    logic sync_pending;
    logic go_data;
    logic load_sync;

    // Cycles remaining after the first one of a slot, per latched width.
    function automatic logic [3:0] hw_cycles(input logic [2:0] w);
        case (w)
            3'd4:    hw_cycles = 4'd1;
            3'd2:    hw_cycles = 4'd3;
            default: hw_cycles = 4'd7;
        endcase
    endfunction

    function automatic logic [3:0] sync_cycles(input logic [2:0] w);
        case (w)
            3'd4:    sync_cycles = 4'd3;
            3'd2:    sync_cycles = 4'd7;
            default: sync_cycles = 4'd15;
        endcase
    endfunction

    function automatic logic [31:0] shift_out(input logic [31:0] s, input logic [2:0] w);
        case (w)
            3'd4:    shift_out = s >> 8;
            3'd2:    shift_out = s >> 4;
            default: shift_out = s >> 2;
        endcase
    endfunction

    always_comb begin
        width_ok = (width == 3'd1) ||
                   ((width == 3'd2) && (BUSWIDTH >= 2)) ||
                   ((width == 3'd4) && (BUSWIDTH >= 4));
        out_en   = (state_q == StSync) || (state_q == StData);
        slot_end = out_en && (cnt_q == 4'd0);
        sync_pending = forceSync ||
                       (frame_cnt_q == 8'(SYNC_FRAMES)) ||
                       (pad_cnt_q == 8'(SYNC_IDLE));
        // A pending sync waits for a frame boundary; a width change does not.
        go_data  = slot_end && width_ok && (width == lw_q) &&
                   !(sync_pending && (word_cnt_q == 3'd0));
    end

    always_comb begin
        state_d      = state_q;
        sh_d         = sh_q;
        lw_d         = lw_q;
        cnt_d        = cnt_q;
        word_cnt_d   = word_cnt_q;
        frame_cnt_d  = frame_cnt_q;
        pad_cnt_d    = pad_cnt_q;
        frame_done_d = 1'b0;
        load_sync    = 1'b0;

        case (state_q)
            StReset, StBad: begin
                if (width_ok) begin
                    load_sync = 1'b1;
                end else begin
                    state_d = StBad;
                end
            end
            default: begin
                if (!slot_end) begin
                    sh_d  = shift_out(sh_q, lw_q);
                    cnt_d = cnt_q - 4'd1;
                end else if (!width_ok) begin
                    state_d = StBad;
                    sh_d    = '0;
                end else if (go_data) begin
                    state_d = StData;
                    cnt_d   = hw_cycles(lw_q);
                    if (WdValid) begin
                        sh_d      = {16'h0000, PacketWd};
                        pad_cnt_d = 8'd0;
                        if (word_cnt_q == 3'd7) begin
                            word_cnt_d   = 3'd0;
                            frame_cnt_d  = frame_cnt_q + 8'd1;
                            frame_done_d = 1'b1;
                        end else begin
                            word_cnt_d = word_cnt_q + 3'd1;
                        end
                    end else begin
                        sh_d = {16'h0000, PadWord};
                        if ((word_cnt_q == 3'd0) && (pad_cnt_q != 8'(SYNC_IDLE))) begin
                            pad_cnt_d = pad_cnt_q + 8'd1;
                        end
                    end
                end else begin
                    load_sync = 1'b1;
                end
            end
        endcase

        if (load_sync) begin
            state_d     = StSync;
            sh_d        = SyncWord;
            lw_d        = width;
            cnt_d       = sync_cycles(width);
            word_cnt_d  = 3'd0;
            frame_cnt_d = 8'd0;
            pad_cnt_d   = 8'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StReset;
            sh_q         <= '0;
            lw_q         <= '0;
            cnt_q        <= '0;
            word_cnt_q   <= '0;
            frame_cnt_q  <= '0;
            pad_cnt_q    <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            sh_q         <= sh_d;
            lw_q         <= lw_d;
            cnt_q        <= cnt_d;
            word_cnt_q   <= word_cnt_d;
            frame_cnt_q  <= frame_cnt_d;
            pad_cnt_q    <= pad_cnt_d;
            frame_done_q <= frame_done_d;
        end
    end

    for (genvar i = 0; i < BUSWIDTH; i++) begin : g_pin
        logic b_bit;
        always_comb begin
            case (lw_q)
                3'd4:    b_bit = sh_q[i+4];
                3'd2:    b_bit = sh_q[i+2];
                default: b_bit = sh_q[i+1];
            endcase
        end
        assign traceDouta[i] = out_en && (32'(lw_q) > i) && sh_q[i];
        assign traceDoutb[i] = out_en && (32'(lw_q) > i) && b_bit;
    end

    assign WdReady    = go_data;
    assign syncActive = (state_q == StSync);
    assign frameDone  = frame_done_q;

endmodule

// File: tb/tb_trace_tpiu_tx.sv
// Directed bench for trace_tpiu_tx: sync/pad patterns, data chunks at each width,
// frame pulses, periodic/forced/width-change syncs, invalid width and reset.
module tb_trace_tpiu_tx;
    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  width;
    logic        forceSync;
    logic        WdValid;
    logic [15:0] PacketWd;
    logic        WdReady;
    logic [3:0]  traceDouta;
    logic [3:0]  traceDoutb;
    logic        syncActive;
    logic        frameDone;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    trace_tpiu_tx #(
        .BUSWIDTH    (4),
        .SYNC_FRAMES (16),
        .SYNC_IDLE   (64)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .width      (width),
        .forceSync  (forceSync),
        .WdValid    (WdValid),
        .PacketWd   (PacketWd),
        .WdReady    (WdReady),
        .traceDouta (traceDouta),
        .traceDoutb (traceDoutb),
        .syncActive (syncActive),
        .frameDone  (frameDone)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (WdReady !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        check(tag, 32'(WdReady), 32'd1);
    endtask

    // Returns one step after the capture edge, with chunk 0 on the pins.
    task automatic send_word(input logic [15:0] d);
        WdValid  = 1'b1;
        PacketWd = d;
        wait_ready("ready_wait");
        tick();
        WdValid = 1'b0;
    endtask

    initial begin
        logic [7:0]  pa;
        logic [7:0]  pb;
        logic [15:0] d;
        int          n;
        int          prev_fd;

        rst = 1'b1; width = 3'd4; forceSync = 1'b0; WdValid = 1'b0; PacketWd = 16'h0;
        tick();
        tick();
        check("rst_a", 32'(traceDouta), 32'h0);
        check("rst_b", 32'(traceDoutb), 32'h0);
        check("rst_ready", 32'(WdReady), 32'h0);
        check("rst_sync", 32'(syncActive), 32'h0);
        check("rst_fd", 32'(frameDone), 32'h0);

        // Full sync at w=4 right after reset release.
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("sync4_a", 32'(traceDouta), 32'hf);
            check("sync4_b", 32'(traceDoutb), (k == 3) ? 32'h7 : 32'hf);
            check("sync4_active", 32'(syncActive), 32'h1);
            check("sync4_ready", 32'(WdReady), (k == 3) ? 32'h1 : 32'h0);
        end

        // 64 idle pads, then an idle sync.
        for (int p = 0; p < 128; p++) begin
            tick();
            check("pad_a", 32'(traceDouta), 32'hf);
            check("pad_b", 32'(traceDoutb), (p % 2 == 1) ? 32'h7 : 32'hf);
            check("pad_active", 32'(syncActive), 32'h0);
        end
        check("idle_noready", 32'(WdReady), 32'h0);
        tick();
        check("idle_sync", 32'(syncActive), 32'h1);

        // Single halfword at w=4.
        send_word(16'h1234);
        check("w4_c0_a", 32'(traceDouta), 32'h4);
        check("w4_c0_b", 32'(traceDoutb), 32'h3);
        check("w4_c0_ready", 32'(WdReady), 32'h0);
        tick();
        check("w4_c1_a", 32'(traceDouta), 32'h2);
        check("w4_c1_b", 32'(traceDoutb), 32'h1);

        // Complete the frame.
        for (int i = 0; i < 7; i++) begin
            send_word(16'h1000 + 16'(i));
            check("w4_fd", 32'(frameDone), (i == 6) ? 32'h1 : 32'h0);
        end

        // forceSync raised after word 3: frame finishes, then sync.
        for (int i = 0; i < 3; i++) send_word(16'h2200 + 16'(i));
        forceSync = 1'b1;
        for (int i = 0; i < 5; i++) send_word(16'h3300 + 16'(i));
        check("force_fd", 32'(frameDone), 32'h1);
        tick();
        check("force_noready", 32'(WdReady), 32'h0);
        tick();
        check("force_sync", 32'(syncActive), 32'h1);
        forceSync = 1'b0;

        // Width change 4->2 mid-frame: sync at the next slot boundary.
        send_word(16'h4400);
        send_word(16'h4401);
        width = 3'd2;
        tick();
        check("wchg_noready", 32'(WdReady), 32'h0);
        tick();
        check("wchg_sync", 32'(syncActive), 32'h1);
        check("wchg_a", 32'(traceDouta), 32'h3);
        check("wchg_b", 32'(traceDoutb), 32'h3);
        n = 0;
        while (syncActive === 1'b1 && n < 40) begin
            tick();
            n++;
        end
        check("w2_sync_len", 32'(n), 32'd8);

        // 16 frames at w=2, then a periodic sync.
        prev_fd = 0;
        for (int i = 0; i < 128; i++) begin
            d = 16'h2000 + 16'(i);
            send_word(d);
            check("w2_nibble", 32'({traceDoutb[1:0], traceDouta[1:0]}), 32'(d[3:0]));
            if (i % 8 == 7) begin
                check("w2_fd", 32'(frameDone), 32'h1);
                if (i > 7) check("w2_fd_gap", 32'(cyc - prev_fd), 32'd32);
                prev_fd = cyc;
            end else begin
                check("w2_fd_low", 32'(frameDone), 32'h0);
            end
        end
        tick();
        tick();
        tick();
        check("w2_last_noready", 32'(WdReady), 32'h0);
        tick();
        check("w2_period_sync", 32'(syncActive), 32'h1);

        // w=1 halfword 0xA5C3, pin 0 pairs.
        width = 3'd1;
        pa = 8'b0011_1001;
        pb = 8'b1100_1001;
        send_word(16'ha5c3);
        for (int k = 0; k < 8; k++) begin
            if (k > 0) tick();
            check("w1_a", 32'(traceDouta), 32'(pa[k]));
            check("w1_b", 32'(traceDoutb), 32'(pb[k]));
        end

        // Invalid width parks in BAD; a valid width resyncs.
        width = 3'd3;
        for (int k = 0; k < 20; k++) tick();
        check("bad_a", 32'(traceDouta), 32'h0);
        check("bad_b", 32'(traceDoutb), 32'h0);
        check("bad_ready", 32'(WdReady), 32'h0);
        check("bad_sync", 32'(syncActive), 32'h0);
        width = 3'd4;
        tick();
        check("unbad_sync", 32'(syncActive), 32'h1);
        check("unbad_a", 32'(traceDouta), 32'hf);

        // Reset mid-slot.
        rst = 1'b1;
        tick();
        check("midrst_a", 32'(traceDouta), 32'h0);
        check("midrst_sync", 32'(syncActive), 32'h0);
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
